// File: rtl/div_unit_if.sv
// Issue and writeback signals between the execute stage and the iterative divider.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic              start;
    logic [1:0]        op;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [4:0]        rd;
    logic              kill;
    logic              busy;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;

    modport master (
        output start, op, rs1_val, rs2_val, rd, kill,
        input  busy, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd, kill,
        output busy, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU with register-file writeback.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_enter_done;

    logic              r_sel_rem;
    logic [4:0]        r_rd;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_busy;
    logic              r_wb_we;
    logic [4:0]        r_wb_addr;
    logic [XLEN-1:0]   r_wb_data;

    logic              w_signed;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_data;

    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN:0]     w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic              w_last;
    logic [XLEN-1:0]   w_fix_q;
    logic [XLEN-1:0]   w_fix_r;
    logic [XLEN-1:0]   w_calc_data;

    logic [4:0]        w_fin_rd;
    logic [XLEN-1:0]   w_fin_data;

    // Operand decode at issue: magnitudes, sign flags and the two special cases.
    always_comb begin
        w_signed    = ~bus.op[0];
        w_s1        = w_signed & bus.rs1_val[XLEN-1];
        w_s2        = w_signed & bus.rs2_val[XLEN-1];
        w_mag1      = w_s1 ? (-bus.rs1_val) : bus.rs1_val;
        w_mag2      = w_s2 ? (-bus.rs2_val) : bus.rs2_val;
        w_div0      = (bus.rs2_val == '0);
        w_ovf       = w_signed && (bus.rs1_val == SMIN) && (bus.rs2_val == '1);
        w_special   = w_div0 | w_ovf;
        w_spec_data = '0;
        if (w_div0) begin
            w_spec_data = bus.op[1] ? bus.rs1_val : '1;
        end else begin
            w_spec_data = bus.op[1] ? '0 : SMIN;
        end
    end

    // One shift-subtract step plus sign fix-up of the final values.
    always_comb begin
        w_shift     = (XLEN+1)'({r_rem, r_quo[XLEN-1]});
        w_ge        = (w_shift >= {1'b0, r_dvs});
        w_rem_nxt   = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
        w_quo_nxt   = {r_quo[XLEN-2:0], w_ge};
        w_last      = (r_cnt == CNT_W'(XLEN-1));
        w_fix_q     = r_neg_q ? (-w_quo_nxt) : w_quo_nxt;
        w_fix_r     = r_neg_r ? (-XLEN'(w_rem_nxt)) : XLEN'(w_rem_nxt);
        w_calc_data = r_sel_rem ? w_fix_r : w_fix_q;
        w_fin_rd    = (r_state == S_IDLE) ? bus.rd : r_rd;
        w_fin_data  = (r_state == S_IDLE) ? w_spec_data : w_calc_data;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    w_accept = 1'b1;
                    if (w_special) begin
                        w_next_state = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                    w_enter_done = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_rem <= 1'b0;
            r_rd      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_sel_rem <= bus.op[1];
            r_rd      <= bus.rd;
            r_rem     <= '0;
            r_quo     <= w_mag1;
            r_dvs     <= w_mag2;
            r_neg_q   <= w_s1 ^ w_s2;
            r_neg_r   <= w_s1;
            r_cnt     <= '0;
        end else if (r_state == S_CALC) begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Registered busy flag and writeback port; data/address hold until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_busy  <= (w_next_state != S_IDLE);
            r_wb_we <= 1'b0;
            if (w_enter_done) begin
                r_wb_we   <= (w_fin_rd != 5'd0);
                r_wb_addr <= w_fin_rd;
                r_wb_data <= w_fin_data;
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.wb_we   = r_wb_we;
    assign bus.wb_addr = r_wb_addr;
    assign bus.wb_data = r_wb_data;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_div_unit;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] SMIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Architectural result of a RISC-V M-extension divide/remainder.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : ovf ? SMIN : 32'($signed(a) / $signed(b));
            2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept to the DONE cycle.
    function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0 || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF)) latency = 1;
        else latency = XLEN + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd      = rd;
    endtask

    // Called at the start of the cycle after accept; checks busy/wb timing through one cycle past DONE.
    task automatic track(input string tag, input int lat, input logic [4:0] rd, input logic [31:0] exp, input bit noise);
        bus.start = 1'b0;
        for (int d = 1; d <= lat + 1; d++) begin
            if (noise) begin
                bus.start   = (d < lat);
                bus.op      = 2'($urandom);
                bus.rs1_val = $urandom;
                bus.rs2_val = $urandom;
                bus.rd      = 5'($urandom);
                bus.kill    = (d == lat);
            end
            @(negedge clk);
            chk({tag, "_busy"}, 32'(bus.busy), 32'(d <= lat));
            chk({tag, "_we"}, 32'(bus.wb_we), 32'((d == lat) && (rd != 5'd0)));
            if (d >= lat) begin
                chk({tag, "_addr"}, 32'(bus.wb_addr), 32'(rd));
                chk({tag, "_data"}, bus.wb_data, exp);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.kill  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noise);
        @(posedge clk); #1;
        drive(op, a, b, rd);
        @(posedge clk); #1;
        track(tag, latency(op, a, b), rd, model(op, a, b), noise);
    endtask

    initial begin
        int pulses;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rrd;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.op      = 2'b00;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_data", bus.wb_data, 32'd0);

        // Directed cases; the first carries start/kill noise while busy.
        run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 1'b1);
        chk("divu_100_7_model", model(2'b01, 32'd100, 32'd7), 32'd14);
        run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
        run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        run("div_ovf", 2'b00, SMIN, 32'hFFFF_FFFF, 5'd6, 1'b0);
        run("rem_ovf", 2'b10, SMIN, 32'hFFFF_FFFF, 5'd7, 1'b1);
        run("divu_z", 2'b01, 32'h1234, 32'd0, 5'd8, 1'b0);
        run("remu_z", 2'b11, 32'h1234, 32'd0, 5'd9, 1'b0);
        run("div_z", 2'b00, 32'hFFFF_0000, 32'd0, 5'd10, 1'b0);
        run("rd0", 2'b01, 32'd1000, 32'd10, 5'd0, 1'b0);

        // Kill during CALC, then an immediate new issue.
        @(posedge clk); #1;
        drive(2'b01, 32'hDEAD_BEEF, 32'd3, 5'd11);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("kill_pre_we", 32'(bus.wb_we), 32'd0);
            @(posedge clk); #1;
        end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        drive(2'b01, 32'd5000, 32'd9, 5'd12);
        @(negedge clk);
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_we", 32'(bus.wb_we), 32'd0);
        @(posedge clk); #1;
        track("after_kill", XLEN + 1, 5'd12, 32'd555, 1'b0);

        // Kill in the same cycle as start: nothing accepted.
        @(posedge clk); #1;
        drive(2'b00, 32'd50, 32'd5, 5'd13);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);
        chk("kill_start_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a CALC.
        @(posedge clk); #1;
        drive(2'b11, 32'd77777, 32'd13, 5'd14);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_we", 32'(bus.wb_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.wb_addr), 32'd0);
        chk("mid_rst_data", bus.wb_data, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_we) pulses++;
        end
        chk("mid_rst_nowrite", 32'(pulses), 32'd0);

        // Randomized ops biased towards the corner cases.
        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = SMIN; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run("rand", rop, ra, rb, rrd, (i % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
